// File: rtl/fifo_pkg.sv
// Shared Gray-pointer helpers for the dual-clock FIFO write and read controllers.
package fifo_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Unused upper bits must be zero; the prefix XOR then leaves them zero.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int unsigned i = 0; i < GRAY_MAX_W - 1; i++)
      b[GRAY_MAX_W-2-i] = b[GRAY_MAX_W-1-i] ^ g[GRAY_MAX_W-2-i];
    return b;
  endfunction

endpackage

// File: rtl/sync_gray_ptr.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
module sync_gray_ptr #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++)
        stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain pointer, flag and fill-level controller for the dual-clock FIFO.
module async_fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  input  logic                  clr_ovf,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] AFULL_L = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] wq_rptr;
  logic [PW-1:0] wq_rbin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_cmp;

  sync_gray_ptr #(
    .WIDTH      (PW),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_rptr (
    .clk(clk),
    .rst(rst),
    .d  (rptr_gray),
    .q  (wq_rptr)
  );

  always_comb begin
    wen        = winc & ~wfull;
    wbin_next  = wbin + PW'(wen);
    wgray_next = PW'(bin2gray(GRAY_MAX_W'(wbin_next)));
    wq_rbin    = PW'(gray2bin(GRAY_MAX_W'(wq_rptr)));
    level_next = wbin_next - wq_rbin;
    // Full when the next write pointer is one lap ahead of the synced read pointer.
    full_cmp   = {~wq_rptr[PW-1:PW-2], wq_rptr[PW-3:0]};
  end

  assign waddr = wbin[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr_gray    <= wgray_next;
      wfull        <= (wgray_next == full_cmp);
      wlevel       <= level_next;
      walmost_full <= (level_next >= AFULL_L);
      if (winc && wfull)
        woverflow <= 1'b1;
      else if (clr_ovf)
        woverflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl with default parameters.
module tb_async_fifo_wr_ctrl;

  logic       clk;
  logic       rst;
  logic       winc;
  logic [3:0] rptr_gray;
  logic       clr_ovf;
  logic       wen;
  logic [2:0] waddr;
  logic [3:0] wptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       woverflow;

  int total = 0;
  int bad   = 0;

  async_fifo_wr_ctrl #(
    .ADDR_WIDTH  (3),
    .SYNC_STAGES (2),
    .AFULL_THRESH(6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .winc        (winc),
    .rptr_gray   (rptr_gray),
    .clr_ovf     (clr_ovf),
    .wen         (wen),
    .waddr       (waddr),
    .wptr_gray   (wptr_gray),
    .wfull       (wfull),
    .walmost_full(walmost_full),
    .wlevel      (wlevel),
    .woverflow   (woverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] gray4(input int unsigned n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ {1'b0, b[3:1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    winc = 0; clr_ovf = 0; rptr_gray = '0; rst = 0;
    tick(); tick();
    rst = 1;
    tick();
    total++;
    if ({wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow} !== 17'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0",
               {wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow});
    end
  endtask

  task automatic test_fill();
    logic [3:0] gexp [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                            4'b0111, 4'b0101, 4'b0100, 4'b1100};
    winc = 1;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (waddr !== 3'(k)) begin
        bad++; $display("FAIL fill_waddr[%0d] got=%0d exp=%0d", k, waddr, k);
      end
      tick();
      total++;
      if (wptr_gray !== gexp[k]) begin
        bad++; $display("FAIL fill_gray[%0d] got=%b exp=%b", k, wptr_gray, gexp[k]);
      end
      total++;
      if (wlevel !== 4'(k + 1)) begin
        bad++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", k, wlevel, k + 1);
      end
      total++;
      if (walmost_full !== (k + 1 >= 6)) begin
        bad++; $display("FAIL fill_afull[%0d] got=%b exp=%b", k, walmost_full, (k + 1 >= 6));
      end
      total++;
      if (wfull !== (k == 7)) begin
        bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", k, wfull, (k == 7));
      end
    end
    winc = 0;
  endtask

  task automatic test_overflow();
    winc = 1;
    #1;
    total++;
    if (wen !== 1'b0) begin bad++; $display("FAIL ovf_wen got=%b exp=0", wen); end
    tick();
    total++;
    if (waddr !== 3'd0 || wptr_gray !== 4'b1100) begin
      bad++; $display("FAIL ovf_hold got=%0d/%b exp=0/1100", waddr, wptr_gray);
    end
    total++;
    if (woverflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", woverflow); end
    clr_ovf = 1;
    tick();
    total++;
    if (woverflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", woverflow); end
    winc = 0;
    tick();
    total++;
    if (woverflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", woverflow); end
    clr_ovf = 0;
  endtask

  task automatic test_drain();
    rptr_gray = 4'b0001;
    tick(); tick();
    total++;
    if (wfull !== 1'b1 || wlevel !== 4'd8) begin
      bad++; $display("FAIL drain_early got=%b/%0d exp=1/8", wfull, wlevel);
    end
    tick();
    total++;
    if (wfull !== 1'b0) begin bad++; $display("FAIL drain_full got=%b exp=0", wfull); end
    total++;
    if (wlevel !== 4'd7) begin bad++; $display("FAIL drain_level got=%0d exp=7", wlevel); end
    total++;
    if (walmost_full !== 1'b1) begin bad++; $display("FAIL drain_afull got=%b exp=1", walmost_full); end
  endtask

  task automatic test_wrap();
    int unsigned lexp;
    test_reset();
    for (int unsigned i = 1; i <= 16; i++) begin
      winc = 1;
      rptr_gray = gray4(i - 1);
      tick();
      lexp = (i <= 3) ? i : 3;
      total++;
      if (wfull !== 1'b0 || walmost_full !== 1'b0) begin
        bad++; $display("FAIL wrap_flags[%0d] got=%b%b exp=00", i, wfull, walmost_full);
      end
      total++;
      if (wlevel !== 4'(lexp)) begin
        bad++; $display("FAIL wrap_level[%0d] got=%0d exp=%0d", i, wlevel, lexp);
      end
    end
    winc = 0;
    total++;
    if (wptr_gray !== 4'b0000 || waddr !== 3'd0) begin
      bad++; $display("FAIL wrap_end got=%b/%0d exp=0000/0", wptr_gray, waddr);
    end
  endtask

  task automatic test_reset_midop();
    test_reset();
    winc = 1;
    repeat (5) tick();
    winc = 0;
    total++;
    if (waddr !== 3'd5) begin bad++; $display("FAIL mid_pre got=%0d exp=5", waddr); end
    #2 rst = 0;
    #1;
    total++;
    if ({wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow} !== 17'd0) begin
      bad++;
      $display("FAIL mid_reset got=%b exp=0",
               {wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow});
    end
    @(negedge clk);
    rst = 1;
    winc = 1;
    #1;
    total++;
    if (waddr !== 3'd0 || wen !== 1'b1) begin
      bad++; $display("FAIL mid_next_addr got=%0d/%b exp=0/1", waddr, wen);
    end
    tick();
    winc = 0;
    total++;
    if (wptr_gray !== 4'b0001) begin
      bad++; $display("FAIL mid_next_gray got=%b exp=0001", wptr_gray);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
